// File: rtl/layer2_weight_sequencer_if.sv
// layer2_weight_sequencer_if: weight stream, storage port and datapath handshake of the layer-2 weight sequencer.
interface layer2_weight_sequencer_if #(
    parameter int NODE_IDX_W       = 5,
    parameter int WEIGHT_W         = 8,
    parameter int WEIGHTS_PER_NODE = 10
);
    localparam int DW = WEIGHTS_PER_NODE * WEIGHT_W;
    logic                  start_load;
    logic                  w_valid;
    logic [WEIGHT_W-1:0]   w_data;
    logic                  w_ready;
    logic                  start_infer;
    logic                  store_write_enable;
    logic [NODE_IDX_W-1:0] store_node_select;
    logic [DW-1:0]         store_write_data;
    logic [DW-1:0]         store_read_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [NODE_IDX_W-1:0] rd_node;
    logic [DW-1:0]         rd_data;
    logic                  busy;
    logic                  weights_loaded;
    logic                  load_done;
    logic                  infer_done;
    modport slave (
        input  start_load, w_valid, w_data, start_infer, store_read_data, rd_ready,
        output w_ready, store_write_enable, store_node_select, store_write_data,
               rd_valid, rd_node, rd_data, busy, weights_loaded, load_done, infer_done
    );
    modport master (
        output start_load, w_valid, w_data, start_infer, store_read_data, rd_ready,
        input  w_ready, store_write_enable, store_node_select, store_write_data,
               rd_valid, rd_node, rd_data, busy, weights_loaded, load_done, infer_done
    );
endinterface

// File: rtl/layer2_weight_sequencer.sv
// layer2_weight_sequencer: packs a serial weight stream into the latch-based layer-2 weight bank and sweeps it for inference.
module layer2_weight_sequencer #(
    parameter int RELU_NODES       = 32,
    parameter int NODE_IDX_W       = 5,
    parameter int WEIGHT_W         = 8,
    parameter int WEIGHTS_PER_NODE = 10
) (
    input logic clk,
    input logic reset,
    layer2_weight_sequencer_if.slave bus
);
    localparam int DW = WEIGHTS_PER_NODE * WEIGHT_W;
    localparam int KW = $clog2(WEIGHTS_PER_NODE > 1 ? WEIGHTS_PER_NODE : 2);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] COLLECT  = 3'd1;
    localparam logic [2:0] SETUP    = 3'd2;
    localparam logic [2:0] WRITE    = 3'd3;
    localparam logic [2:0] HOLD     = 3'd4;
    localparam logic [2:0] RD_SETUP = 3'd5;
    localparam logic [2:0] RD_VALID = 3'd6;
    localparam logic [NODE_IDX_W-1:0] NODE_LAST = NODE_IDX_W'(RELU_NODES - 1);
    localparam logic [KW-1:0]         K_LAST    = KW'(WEIGHTS_PER_NODE - 1);

    logic [2:0]            r_state;
    logic [NODE_IDX_W-1:0] r_node;
    logic [KW-1:0]         r_k;
    logic [DW-1:0]         r_pack;
    logic                  r_loaded;
    logic                  r_load_done;
    logic                  r_infer_done;
    logic                  w_node_last;
    logic                  w_k_last;

    assign w_node_last = r_node == NODE_LAST;
    assign w_k_last    = r_k == K_LAST;

    // The packing register doubles as the storage write bus: it only changes in COLLECT,
    // so select and data are frozen across SETUP/WRITE/HOLD and hold their value afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_node       <= '0;
            r_k          <= '0;
            r_pack       <= '0;
            r_loaded     <= 1'b0;
            r_load_done  <= 1'b0;
            r_infer_done <= 1'b0;
        end else begin
            r_load_done  <= 1'b0;
            r_infer_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start_load) begin
                        r_state  <= COLLECT;
                        r_node   <= '0;
                        r_k      <= '0;
                        r_loaded <= 1'b0;
                    end else if (bus.start_infer && r_loaded) begin
                        r_state <= RD_SETUP;
                        r_node  <= '0;
                    end
                end
                COLLECT: begin
                    if (bus.w_valid) begin
                        r_pack[r_k*WEIGHT_W +: WEIGHT_W] <= bus.w_data;
                        r_k     <= w_k_last ? '0 : r_k + 1'b1;
                        r_state <= w_k_last ? SETUP : COLLECT;
                    end
                end
                SETUP: r_state <= WRITE;
                WRITE: r_state <= HOLD;
                HOLD: begin
                    if (w_node_last) begin
                        r_state     <= IDLE;
                        r_loaded    <= 1'b1;
                        r_load_done <= 1'b1;
                    end else begin
                        r_state <= COLLECT;
                        r_node  <= r_node + 1'b1;
                    end
                end
                RD_SETUP: r_state <= RD_VALID;
                RD_VALID: begin
                    if (bus.rd_ready) begin
                        r_state      <= w_node_last ? IDLE : RD_SETUP;
                        r_node       <= w_node_last ? r_node : r_node + 1'b1;
                        r_infer_done <= w_node_last;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.w_ready            = r_state == COLLECT;
    assign bus.store_write_enable = r_state == WRITE;
    assign bus.store_node_select  = r_node;
    assign bus.store_write_data   = r_pack;
    assign bus.rd_valid           = r_state == RD_VALID;
    assign bus.rd_node            = r_node;
    assign bus.rd_data            = bus.store_read_data;
    assign bus.busy               = r_state != IDLE;
    assign bus.weights_loaded     = r_loaded;
    assign bus.load_done          = r_load_done;
    assign bus.infer_done         = r_infer_done;
endmodule

// File: tb/tb_layer2_weight_sequencer.sv
// tb_layer2_weight_sequencer: table vectors plus randomized load/inference sweeps against a storage model and packing reference.
module tb_layer2_weight_sequencer;
    localparam int RN = 32;
    localparam int NW = 5;
    localparam int W  = 8;
    localparam int WPN = 10;
    localparam int DW = W * WPN;
    localparam int RW = 1 + NW + DW;

    typedef struct {
        logic       rst, sl, si, wv;
        logic [6:0] exp;
    } vec_t;
    typedef struct packed {
        logic [RW-1:0] pre, dur, post;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int vectors = 0;
    int miscompares = 0;
    int ld_cnt = 0;
    wr_t wq[$];
    logic [DW-1:0] expk [RN];
    logic [DW-1:0] mem [RN];
    logic [RW-1:0] h1, h2, cur;
    logic e1 = 1'b0;
    vec_t tbl [8];

    layer2_weight_sequencer_if #(.NODE_IDX_W(NW), .WEIGHT_W(W), .WEIGHTS_PER_NODE(WPN)) bus ();
    layer2_weight_sequencer #(.RELU_NODES(RN), .NODE_IDX_W(NW), .WEIGHT_W(W), .WEIGHTS_PER_NODE(WPN)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.store_write_enable) mem[bus.store_node_select] <= bus.store_write_data;
    assign bus.store_read_data = mem[bus.store_node_select];

    // Capture {ready, select, data} one cycle before, during and after every enable pulse.
    always @(negedge clk) begin
        cur = {bus.w_ready, bus.store_node_select, bus.store_write_data};
        if (e1) wq.push_back({h2, h1, cur});
        if (bus.load_done) ld_cnt++;
        h2 = h1;
        h1 = cur;
        e1 = bus.store_write_enable;
    end

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic logic [6:0] obs();
        return {bus.busy, bus.w_ready, bus.store_write_enable, bus.rd_valid,
                bus.weights_loaded, bus.load_done, bus.infer_done};
    endfunction

    task automatic send_w(input logic [W-1:0] v, input bit gap);
        int n = 0;
        if (gap) begin
            bus.w_valid = 1'b0;
            @(negedge clk);
        end
        bus.w_valid = 1'b1;
        bus.w_data  = v;
        while (!bus.w_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.w_ready) chk("w_ready_wait", 0, 1);
        @(negedge clk);
        bus.w_valid = 1'b0;
    endtask

    task automatic load(input int nodes, input bit gap, input bit rnd);
        int base = wq.size();
        int ld0 = ld_cnt;
        int n = 0;
        logic [W-1:0] v;
        wr_t r;
        bus.start_load = 1'b1;
        @(negedge clk);
        bus.start_load = 1'b0;
        for (int i = 0; i < nodes; i++) begin
            for (int k = 0; k < WPN; k++) begin
                v = rnd ? W'($urandom) : W'(i * 10 + k);
                expk[i][k*W +: W] = v;
                send_w(v, gap);
            end
            if (i == 0 && !gap) begin
                chk("lat_setup", {bus.w_ready, bus.store_write_enable}, 2'b00);
                @(negedge clk);
                chk("lat_write", {bus.w_ready, bus.store_write_enable}, 2'b01);
                @(negedge clk);
                chk("lat_hold", {bus.w_ready, bus.store_write_enable}, 2'b00);
                @(negedge clk);
                chk("lat_ready", {bus.w_ready, bus.store_write_enable}, 2'b10);
            end
        end
        if (nodes == RN) begin
            while (bus.busy && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("load_idle", bus.busy, 0);
            chk("load_done_pulse", {bus.load_done, bus.weights_loaded}, 2'b11);
            @(negedge clk);
            chk("load_done_count", ld_cnt - ld0, 1);
            chk("load_done_clear", {bus.load_done, bus.weights_loaded}, 2'b01);
            chk("write_count", wq.size() - base, RN);
            for (int i = 0; i < RN && base + i < wq.size(); i++) begin
                r = wq[base + i];
                chk($sformatf("write_node%0d", i), r.dur, {1'b0, NW'(i), expk[i]});
                chk($sformatf("write_pre%0d", i), r.pre, r.dur);
                chk($sformatf("write_post%0d", i), r.post, r.dur);
            end
        end
    endtask

    task automatic infer(input int stall);
        int g;
        bus.rd_ready    = 1'b1;
        bus.start_infer = 1'b1;
        @(negedge clk);
        bus.start_infer = 1'b0;
        for (int i = 0; i < RN; i++) begin
            g = 0;
            while (!bus.rd_valid && g < 10) begin
                @(negedge clk);
                g++;
            end
            chk($sformatf("rd_gap%0d", i), g, 1);
            chk($sformatf("rd_node%0d", i), {bus.rd_node, bus.store_node_select}, {NW'(i), NW'(i)});
            chk($sformatf("rd_data%0d", i), bus.rd_data, expk[i]);
            if (i == stall) begin
                bus.rd_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("rd_stall", {bus.rd_valid, bus.rd_node, bus.store_node_select}, {1'b1, NW'(i), NW'(i)});
                end
                bus.rd_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("infer_done_pulse", {bus.infer_done, bus.busy, bus.rd_valid}, 3'b100);
        bus.rd_ready = 1'b0;
        @(negedge clk);
        chk("infer_done_clear", bus.infer_done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.start_load = 1'b0;
        bus.start_infer = 1'b0;
        bus.w_valid = 1'b0;
        bus.w_data = 8'hA5;
        bus.rd_ready = 1'b0;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b0000000};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 7'b1100000};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b1100000};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 7'b1100000};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b1100000};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000};
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            reset = tbl[i].rst;
            bus.start_load = tbl[i].sl;
            bus.start_infer = tbl[i].si;
            bus.w_valid = tbl[i].wv;
            @(negedge clk);
            chk($sformatf("table%0d", i), obs(), tbl[i].exp);
        end
        reset = 1'b0;
        bus.start_load = 1'b0;
        bus.start_infer = 1'b0;
        bus.w_valid = 1'b0;
        chk("reset_regs", {bus.store_node_select, bus.rd_node, bus.store_write_data}, 0);

        load(RN, 1'b0, 1'b0);
        load(RN, 1'b1, 1'b1);
        infer(7);

        load(4, 1'b0, 1'b1);
        @(negedge clk);
        chk("write_node3", {bus.store_write_enable, bus.store_node_select}, {1'b1, NW'(3)});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_in_write", {obs(), bus.store_node_select}, 0);
        bus.start_infer = 1'b1;
        @(negedge clk);
        bus.start_infer = 1'b0;
        chk("infer_unloaded", obs(), 0);
        load(RN, 1'b0, 1'b1);
        infer(-1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/layer2_weight_sequencer.md
Name: layer2_weight_sequencer

Overview:
- Controller in front of the layer-2 weight storage, a latch-based bank of RELU_NODES entries, each WEIGHTS_PER_NODE x WEIGHT_W bits.
- Load mode: accepts a serial weight stream, packs WEIGHTS_PER_NODE weights per node, and writes each packed node into the storage with a glitch-safe setup/enable/hold sequence.
- Inference mode: steps the storage node select 0..RELU_NODES-1 and presents each node's weight vector to the layer-2 datapath over a valid/ready handshake.

Parameters:
RELU_NODES, 32, number of RELU nodes (storage entries)
NODE_IDX_W, 5, width of the node index; must satisfy 2^NODE_IDX_W >= RELU_NODES
WEIGHT_W, 8, bits per weight
WEIGHTS_PER_NODE, 10, weights packed per storage entry

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
start_load  in  1  one-cycle request to begin a full weight load
w_valid  in  1  a weight is offered on w_data
w_data  in  WEIGHT_W  weight value
w_ready  out  1  sequencer accepts w_data this cycle
start_infer  in  1  one-cycle request to begin an inference sweep
store_write_enable  out  1  storage write enable (level, latch transparent while high)
store_node_select  out  NODE_IDX_W  storage node index (write target and read mux select)
store_write_data  out  WEIGHTS_PER_NODE*WEIGHT_W  packed weights to storage
store_read_data  in  WEIGHTS_PER_NODE*WEIGHT_W  storage read-out for store_node_select
rd_valid  out  1  rd_data/rd_node valid for the datapath
rd_ready  in  1  datapath consumes the current node
rd_node  out  NODE_IDX_W  node index of rd_data
rd_data  out  WEIGHTS_PER_NODE*WEIGHT_W  equals store_read_data
busy  out  1  high in any state other than IDLE
weights_loaded  out  1  sticky: all RELU_NODES entries written since the last reset or start_load
load_done  out  1  one-cycle pulse when the final node write completes
infer_done  out  1  one-cycle pulse when the final node is consumed

Behaviour:
- Reset values:
  - State IDLE; node and weight counters 0.
  - All outputs 0: w_ready, store_write_enable, store_node_select, store_write_data, rd_valid, rd_node, busy, weights_loaded, load_done, infer_done.
  - rd_data follows store_read_data.
- Reset mid-operation returns to IDLE immediately, with the same values, regardless of state.
- IDLE:
  - start_load -> COLLECT; node counter 0; weights_loaded cleared.
  - Else start_infer with weights_loaded=1 -> RD_SETUP; node counter 0.
  - start_infer with weights_loaded=0 is ignored.
  - Both starts high in the same cycle: load wins.
  - Starts outside IDLE are ignored.
- COLLECT:
  - w_ready=1.
  - On w_valid&w_ready, w_data is placed in slice k ([k*WEIGHT_W +: WEIGHT_W]), where k is the weight counter (first weight goes to slice 0); k increments.
  - Accepting weight k=WEIGHTS_PER_NODE-1 -> SETUP; k returns to 0.
  - w_valid low stalls indefinitely with no timeout.
- SETUP (1 cycle):
  - w_ready=0; store_node_select=node counter; store_write_data=packed register; enable 0.
  - -> WRITE.
- WRITE (1 cycle): store_write_enable=1; select and data unchanged. -> HOLD.
- HOLD (1 cycle):
  - store_write_enable=0; select and data unchanged.
  - If node=RELU_NODES-1: load_done pulse, weights_loaded=1, -> IDLE.
  - Else node+1, -> COLLECT.
- Latency and invariants:
  - The 10th weight accepted at cycle T gives SETUP at T+1, enable high at T+2, HOLD at T+3, and w_ready high again at T+4.
  - Select and data never change in the cycle enable is high, nor the cycle before or after.
  - store_write_enable is never high outside WRITE.
- RD_SETUP (1 cycle):
  - store_node_select=node counter; rd_valid=0.
  - One settle cycle for the combinational storage mux.
  - -> RD_VALID.
- RD_VALID:
  - rd_valid=1; rd_node=node counter; rd_data=store_read_data; select held.
  - rd_ready low: stay, all outputs stable.
  - rd_valid&rd_ready at node RELU_NODES-1: infer_done pulse next cycle, -> IDLE.
  - Otherwise node+1, -> RD_SETUP.
  - Throughput: 1 node per 2 cycles.
- Counters never exceed RELU_NODES-1 or WEIGHTS_PER_NODE-1; no wrap occurs because the FSM exits at the last index.
- Outside load states, store_write_data holds its last value.

Test Plan:
- Reset, then start_load; stream weights n*10+k (WEIGHT_W=8, truncated) back-to-back for all 32 nodes -> each node sees exactly one enable pulse with select=n and slice k=n*10+k; select/data are stable one cycle either side; load_done pulses once; weights_loaded=1; total ~32*(10+3) cycles.
- Load with w_valid toggling every other cycle -> packing order is unchanged and w_ready=0 during SETUP/WRITE/HOLD.
- start_infer with rd_ready held high on a storage model -> rd_node steps 0..31, rd_valid every 2nd cycle, rd_data matches the loaded values, infer_done pulses after node 31.
- Inference with rd_ready low for 5 cycles at node 7 -> rd_valid, rd_node=7 and select stay constant; resumes at node 8 when rd_ready rises.
- start_infer before any load -> ignored, busy=0; start_load and start_infer in the same cycle -> load mode entered.
- Assert reset during WRITE at node 3 -> next cycle store_write_enable=0, IDLE, weights_loaded=0; a following full load completes normally.
